// File: rtl/mem_access.sv
// MEM-stage load/store unit: checks size/alignment, drives a request/grant/response
// data bus, aligns store data, extends load data and registers the write-back bundle.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_read_flag_in,
    input  logic        mem_write_flag_in,
    input  logic        mem_sign_ext_flag_in,
    input  logic [3:0]  mem_sel_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [31:0] result_in,
    input  logic        reg_write_en_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [31:0] current_pc_addr_in,
    output logic        data_req,
    output logic        data_we,
    output logic [31:0] data_addr,
    output logic [3:0]  data_be,
    output logic [31:0] data_wdata,
    input  logic        data_gnt,
    input  logic        data_rvalid,
    input  logic [31:0] data_rdata,
    output logic        load_busy,
    output logic        out_valid,
    output logic [31:0] result_out,
    output logic        reg_write_en_out,
    output logic [4:0]  reg_write_addr_out,
    output logic [31:0] current_pc_addr_out,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic            cap_en;

    // Bundle captured on acceptance of a memory op; the bus is driven from these.
    logic            cap_store_q, cap_sign_q, cap_rwe_q;
    logic [3:0]      cap_sel_q, be_q;
    logic [31:0]     cap_addr_q, wdata_q, cap_pc_q;
    logic [4:0]      cap_raddr_q;

    logic            out_valid_q, out_valid_d, addr_err_q, addr_err_d, bus_err_q, bus_err_d;
    logic            rwe_q, rwe_d;
    logic [4:0]      raddr_q, raddr_d;
    logic [31:0]     result_q, result_d, pc_q, pc_d;

    logic            is_mem, sel_legal, misaligned, acc_err, timeout_hit;
    logic [3:0]      be_calc;
    logic [31:0]     wdata_calc, shifted, load_val;

    assign is_mem    = mem_read_flag_in | mem_write_flag_in;
    assign sel_legal = (mem_sel_in == 4'b0001) || (mem_sel_in == 4'b0011) || (mem_sel_in == 4'b1111);
    assign misaligned = ((mem_sel_in == 4'b0011) && result_in[0]) ||
                        ((mem_sel_in == 4'b1111) && (result_in[1:0] != 2'b00));
    assign acc_err   = !sel_legal || misaligned;
    assign be_calc   = mem_sel_in << result_in[1:0];

    always_comb begin
        case (mem_sel_in)
            4'b0001: wdata_calc = {4{mem_write_data_in[7:0]}};
            4'b0011: wdata_calc = {2{mem_write_data_in[15:0]}};
            default: wdata_calc = mem_write_data_in;
        endcase
    end

    assign shifted = data_rdata >> {cap_addr_q[1:0], 3'b000};

    always_comb begin
        case (cap_sel_q)
            4'b0001: load_val = {{24{cap_sign_q & shifted[7]}}, shifted[7:0]};
            4'b0011: load_val = {{16{cap_sign_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (wd_q == CW'(TIMEOUT));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        wd_d        = wd_q;
        cap_en      = 1'b0;
        out_valid_d = 1'b0;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        result_d    = result_q;
        rwe_d       = rwe_q;
        raddr_d     = raddr_q;
        pc_d        = pc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem || acc_err) begin
                        out_valid_d = 1'b1;
                        result_d    = result_in;
                        rwe_d       = !is_mem && reg_write_en_in;
                        raddr_d     = reg_write_addr_in;
                        pc_d        = current_pc_addr_in;
                        addr_err_d  = is_mem;
                    end else begin
                        cap_en  = 1'b1;
                        state_d = REQ;
                        wd_d    = '0;
                    end
                end
            end
            REQ, WAIT: begin
                if (state_q == REQ && data_gnt) begin
                    wd_d = '0;
                    if (cap_store_q) begin
                        out_valid_d = 1'b1;
                        result_d    = cap_addr_q;
                        rwe_d       = 1'b0;
                        raddr_d     = cap_raddr_q;
                        pc_d        = cap_pc_q;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (state_q == WAIT && data_rvalid) begin
                    out_valid_d = 1'b1;
                    result_d    = load_val;
                    rwe_d       = cap_rwe_q;
                    raddr_d     = cap_raddr_q;
                    pc_d        = cap_pc_q;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    out_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                    result_d    = cap_addr_q;
                    rwe_d       = 1'b0;
                    raddr_d     = cap_raddr_q;
                    pc_d        = cap_pc_q;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            cap_store_q <= 1'b0;
            cap_sign_q  <= 1'b0;
            cap_rwe_q   <= 1'b0;
            cap_sel_q   <= '0;
            be_q        <= '0;
            cap_addr_q  <= '0;
            wdata_q     <= '0;
            cap_pc_q    <= '0;
            cap_raddr_q <= '0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            rwe_q       <= 1'b0;
            raddr_q     <= '0;
            result_q    <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            out_valid_q <= out_valid_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
            rwe_q       <= rwe_d;
            raddr_q     <= raddr_d;
            result_q    <= result_d;
            pc_q        <= pc_d;
            if (cap_en) begin
                cap_store_q <= mem_write_flag_in;
                cap_sign_q  <= mem_sign_ext_flag_in;
                cap_rwe_q   <= reg_write_en_in;
                cap_sel_q   <= mem_sel_in;
                be_q        <= be_calc;
                cap_addr_q  <= result_in;
                wdata_q     <= wdata_calc;
                cap_pc_q    <= current_pc_addr_in;
                cap_raddr_q <= reg_write_addr_in;
            end
        end
    end

    assign in_ready            = (state_q == IDLE);
    assign data_req            = (state_q == REQ);
    assign data_we             = cap_store_q;
    assign data_addr           = {cap_addr_q[31:2], 2'b00};
    assign data_be             = be_q;
    assign data_wdata          = wdata_q;
    assign load_busy           = (state_q != IDLE) && !cap_store_q;
    assign out_valid           = out_valid_q;
    assign result_out          = result_q;
    assign reg_write_en_out    = rwe_q;
    assign reg_write_addr_out  = raddr_q;
    assign current_pc_addr_out = pc_q;
    assign addr_err            = addr_err_q;
    assign bus_err             = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: randomized bundles, a byte-lane reference model,
// a bus responder that checks requests, and a monitor that checks the WB bundle.
module tb_mem_access;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready;
    logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in, result_in, current_pc_addr_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        load_busy, out_valid, reg_write_en_out, addr_err, bus_err;
    logic [31:0] result_out, current_pc_addr_out;
    logic [4:0]  reg_write_addr_out;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
        .mem_sign_ext_flag_in(mem_sign_ext_flag_in), .mem_sel_in(mem_sel_in),
        .mem_write_data_in(mem_write_data_in), .result_in(result_in),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .current_pc_addr_in(current_pc_addr_in),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_be(data_be),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .load_busy(load_busy), .out_valid(out_valid),
        .result_out(result_out), .reg_write_en_out(reg_write_en_out),
        .reg_write_addr_out(reg_write_addr_out), .current_pc_addr_out(current_pc_addr_out),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] result; bit chk_result; logic rwe; logic [4:0] raddr; bit chk_raddr;
        logic [31:0] pc; logic aerr; logic berr;
    } exp_t;
    // mode: 0 normal, 1 read never answered in time, 2 reset while waiting
    typedef struct {
        logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] rdata;
        int gdly; int rdly; int mode;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int total = 0, bad = 0, ov_seen = 0;
    bit hold_ok = 0;
    logic [31:0] last_res, last_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int size_of(input logic [3:0] sel);
        case (sel)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int off, input int sz);
        logic [3:0] be = '0;
        for (int i = 0; i < sz; i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = d[8*(j % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off, input int sz,
                                               input logic sx);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
        if (sx && v[8*sz - 1])
            for (int k = 8*sz; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                         input logic [31:0] wd, input logic [31:0] addr, input logic rwe,
                         input logic [4:0] ra, input logic [31:0] pc, input int gdly,
                         input int rdly, input logic [31:0] rdata, input int mode);
        exp_t e;
        bus_t b;
        int sz, off, n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_wait", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        mem_read_flag_in = rd; mem_write_flag_in = wr; mem_sign_ext_flag_in = sx;
        mem_sel_in = sel; mem_write_data_in = wd; result_in = addr;
        reg_write_en_in = rwe; reg_write_addr_in = ra; current_pc_addr_in = pc;
        sz  = size_of(sel);
        off = int'(addr[1:0]);
        e = '{result: addr, chk_result: 1'b1, rwe: 1'b0, raddr: ra, chk_raddr: 1'b0,
              pc: pc, aerr: 1'b0, berr: 1'b0};
        if (!(rd || wr)) begin
            e.rwe = rwe;
            e.chk_raddr = 1'b1;
            exp_q.push_back(e);
        end else if (sz == 0 || (off % sz) != 0) begin
            e.aerr = 1'b1;
            exp_q.push_back(e);
        end else begin
            b = '{we: wr, addr: {addr[31:2], 2'b00}, be: model_be(off, sz),
                  wdata: model_wdata(wd, sz), rdata: rdata, gdly: gdly, rdly: rdly, mode: mode};
            bus_q.push_back(b);
            e.chk_result = 1'b0;
            if (mode == 1) begin
                e.berr = 1'b1;
                exp_q.push_back(e);
            end else if (mode == 0) begin
                if (!wr) begin
                    e.result = model_load(rdata, off, sz, sx);
                    e.chk_result = 1'b1;
                    e.rwe = rwe;
                    e.chk_raddr = 1'b1;
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size() + bus_q.size()), 0);
    endtask

    // Monitor: compares every WB bundle against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                ov_seen++;
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_result) check("result_out", result_out, e.result);
                    check("reg_write_en_out", reg_write_en_out, e.rwe);
                    if (e.chk_raddr) check("reg_write_addr_out", reg_write_addr_out, e.raddr);
                    check("current_pc_addr_out", current_pc_addr_out, e.pc);
                    check("addr_err", addr_err, e.aerr);
                    check("bus_err", bus_err, e.berr);
                end
                last_res = result_out;
                last_pc  = current_pc_addr_out;
                hold_ok  = 1'b1;
            end else begin
                check("addr_err_no_pulse", addr_err, 0);
                check("bus_err_no_pulse", bus_err, 0);
                if (hold_ok) begin
                    check("result_hold", result_out, last_res);
                    check("pc_hold", current_pc_addr_out, last_pc);
                end
            end
        end
    end

    // Bus responder: checks each request, grants after a delay, returns read data.
    initial begin : responder
        bus_t t;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        forever begin
            @(negedge clk);
            if (data_req && !rst) begin
                if (bus_q.size() == 0) begin
                    check("spurious_data_req", data_req, 0);
                end else begin
                    t = bus_q.pop_front();
                    check("data_we", data_we, t.we);
                    check("data_addr", data_addr, t.addr);
                    check("data_be", data_be, t.be);
                    if (t.we) check("data_wdata", data_wdata, t.wdata);
                    for (int i = 0; i < t.gdly; i++) begin
                        @(negedge clk);
                        check("req_held", data_req, 1);
                        check("addr_held", data_addr, t.addr);
                        check("be_held", data_be, t.be);
                    end
                    data_gnt = 1'b1;
                    @(posedge clk);
                    #1 data_gnt = 1'b0;
                    if (!t.we) begin
                        @(negedge clk);
                        check("req_drop_after_gnt", data_req, 0);
                        if (t.mode == 1) repeat (TIMEOUT + 5) @(negedge clk);
                        else repeat (t.rdly - 1) @(negedge clk);
                        data_rdata  = t.rdata;
                        data_rvalid = 1'b1;
                        @(posedge clk);
                        #1 data_rvalid = 1'b0;
                        data_rdata = $urandom;
                    end
                end
            end
        end
    end

    initial begin : main
        int kind, lat, ov0, n;
        logic rd, wr, sx, rwe;
        logic [3:0] sel;
        logic [31:0] addr;
        rst = 1'b1; in_valid = 1'b0;
        mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_ext_flag_in = 0;
        mem_sel_in = '0; mem_write_data_in = '0; result_in = '0;
        reg_write_en_in = 0; reg_write_addr_in = '0; current_pc_addr_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data_req", data_req, 0);
        check("rst_result_out", result_out, 0);
        check("rst_load_busy", load_busy, 0);
        check("rst_data_be", data_be, 0);

        // Pass-through, latency 1
        issue(0, 0, 0, 4'b0000, 32'h0, 32'h0000_1234, 1, 5, 32'h0000_0100, 0, 1, 0, 0);
        @(negedge clk);
        check("pt_latency", out_valid, 1);
        check("pt_no_req", data_req, 0);
        // Byte store at the top lane, granted after 2 cycles
        issue(0, 1, 0, 4'b0001, 32'h0000_00AB, 32'h0000_1003, 1, 7, 32'h0000_0104, 2, 1, 0, 0);
        // Half loads from the upper half, signed then unsigned
        issue(1, 0, 1, 4'b0011, 32'h0, 32'h0000_2002, 1, 9, 32'h0000_0108, 0, 1, 32'h8001_7FFF, 0);
        issue(1, 0, 0, 4'b0011, 32'h0, 32'h0000_2002, 1, 9, 32'h0000_010C, 1, 2, 32'h8001_7FFF, 0);
        // Misaligned word load
        issue(1, 0, 0, 4'b1111, 32'h0, 32'h0000_3001, 1, 3, 32'h0000_0110, 0, 1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 99);
            addr = $urandom;
            sx   = 1'($urandom);
            rwe  = 1'($urandom);
            if (kind < 25) begin
                rd = 0; wr = 0; sel = 4'($urandom);
            end else if (kind < 85) begin
                case ($urandom_range(0, 2))
                    0: sel = 4'b0001;
                    1: begin sel = 4'b0011; addr[0] = 1'b0; end
                    default: begin sel = 4'b1111; addr[1:0] = 2'b00; end
                endcase
                if (kind < 55) begin wr = 1; rd = 1'($urandom); end
                else begin wr = 0; rd = 1; end
            end else begin
                rd = 1'($urandom); wr = !rd;
                if ($urandom_range(0, 1) == 0) begin
                    sel = 4'($urandom);
                    while (size_of(sel) != 0) sel = 4'($urandom);
                end else begin
                    sel = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1111;
                    addr[0] = 1'b1;
                end
            end
            issue(rd, wr, sx, sel, $urandom, addr, rwe, 5'($urandom), $urandom,
                  $urandom_range(0, 2), $urandom_range(1, 3), $urandom, 0);
        end
        drain();

        // Watchdog: granted load never answered within TIMEOUT; late rvalid is ignored
        ov0 = ov_seen;
        issue(1, 0, 0, 4'b1111, 32'h0, 32'h0000_4000, 1, 4, 32'hCAFE_0000, 0, 1, 32'h1111_2222, 1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        check("timeout_latency_in_window", 32'(lat >= TIMEOUT + 1 && lat <= TIMEOUT + 4), 1);
        check("timeout_req_low", data_req, 0);
        check("timeout_in_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        check("late_rvalid_ignored", 32'(ov_seen - ov0), 1);
        drain();

        // Reset while waiting for read data; rvalid the cycle after is ignored
        issue(1, 0, 1, 4'b0011, 32'h0, 32'h0000_5002, 1, 6, 32'hBEEF_0000, 1, 2, 32'hFFFF_0000, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(load_busy && !data_req) && n < 20);
        check("reached_wait", 32'(load_busy && !data_req), 1);
        hold_ok = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ov0 = ov_seen;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result_out", result_out, 0);
        check("mid_rst_reg_we", reg_write_en_out, 0);
        check("mid_rst_reg_addr", reg_write_addr_out, 0);
        check("mid_rst_pc", current_pc_addr_out, 0);
        check("mid_rst_data_req", data_req, 0);
        check("mid_rst_data_we", data_we, 0);
        check("mid_rst_data_addr", data_addr, 0);
        check("mid_rst_data_be", data_be, 0);
        check("mid_rst_data_wdata", data_wdata, 0);
        check("mid_rst_load_busy", load_busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        repeat (4) @(negedge clk);
        check("post_rst_no_out_valid", 32'(ov_seen - ov0), 0);

        issue(0, 0, 0, 4'b0000, 32'h0, 32'h0000_ABCD, 1, 12, 32'h0000_0200, 0, 1, 0, 0);
        @(negedge clk);
        check("recover_latency", out_valid, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
